// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Hazard and pipeline-control unit for the 5-stage RV32I core. It produces every
// PC/pipeline-register write enable, flush and bubble, plus the EX forwarding selects and
// the ID write-through bypass selects. It also handles a variable-latency data-memory wait
// with a timeout. It carries no datapath-width signals.
//
// Parameters
//   REG_AW        register address width
//   BRANCH_STAGE  stage where redirects resolve: 2 = EX, 3 = MEM
//   MEM_TIMEOUT   max frozen cycles for one data-memory access before forced release (>= 1)
//   CNT_W         performance-counter width
//
// Ports
//   clk, reset                         rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2        ID-stage source registers and their use flags
//   idex_rd/rs1/rs2, idex_reg_write,
//   idex_is_load                       ID/EX fields
//   exmem_rd, exmem_reg_write,
//   exmem_is_load                      EX/MEM fields
//   memwb_rd, memwb_reg_write          MEM/WB fields
//   redirect                           taken branch/jump resolved at BRANCH_STAGE
//   dmem_req, dmem_ready               EX/MEM load/store and data-memory completion
//   pc_write .. ex_mem_write           register write enables
//   if_id_flush .. mem_wb_bubble       bubble inserts
//   pc_sel_redirect                    next PC takes the redirect target
//   fwd_a, fwd_b                       EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   byp_a, byp_b                       ID read takes MEM/WB write data
//   mem_err                            sticky data-memory timeout flag
//   stall_cnt, flush_cnt               saturating performance counters
//
// Configuration macro
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt/flush_cnt are implemented. When undefined,
//                       the counters are removed and both outputs are tied to zero.

module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned BRANCH_STAGE = 3,
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,

   input  logic [REG_AW-1:0] idex_rd,
   input  logic [REG_AW-1:0] idex_rs1,
   input  logic [REG_AW-1:0] idex_rs2,
   input  logic              idex_reg_write,
   input  logic              idex_is_load,

   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              exmem_reg_write,
   input  logic              exmem_is_load,

   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              memwb_reg_write,

   input  logic              redirect,
   input  logic              dmem_req,
   input  logic              dmem_ready,

   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_write,
   output logic              ex_mem_write,

   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_flush,
   output logic              mem_wb_bubble,

   output logic              pc_sel_redirect,

   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              byp_a,
   output logic              byp_b,

   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned       WcntW    = $clog2(MEM_TIMEOUT + 1);
   // Value of wcnt in the MEM_WAIT cycle that is released by timeout.
   localparam logic [WcntW-1:0]  WcntLast = WcntW'(MEM_TIMEOUT - 1);
   localparam logic              RedirFlushExMem = (BRANCH_STAGE == 3);

   typedef enum logic [0:0] {
      StRun,
      StMemWait
   } state_e;

   state_e            state_q, state_d;
   logic [WcntW-1:0]  wcnt_q, wcnt_d;
   logic              mem_err_q, mem_err_d;

   logic              freeze;
   logic              load_use;
   logic              exmem_fwd_ok;
   logic              memwb_fwd_ok;

   // ------------------------------------------------------------------------------------
   // Hazard decode
   // ------------------------------------------------------------------------------------

   assign load_use = idex_is_load && (idex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                      (id_use_rs2 && (id_rs2 == idex_rd)));

   // Load data is not available until MEM/WB, so an EX/MEM load is never a forward source.
   assign exmem_fwd_ok = exmem_reg_write && (exmem_rd != '0) && !exmem_is_load;
   assign memwb_fwd_ok = memwb_reg_write && (memwb_rd != '0);

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      byp_a = 1'b0;
      byp_b = 1'b0;
      if (!reset) begin
         if (exmem_fwd_ok && (exmem_rd == idex_rs1)) begin
            fwd_a = 2'b10;
         end else if (memwb_fwd_ok && (memwb_rd == idex_rs1)) begin
            fwd_a = 2'b01;
         end

         if (exmem_fwd_ok && (exmem_rd == idex_rs2)) begin
            fwd_b = 2'b10;
         end else if (memwb_fwd_ok && (memwb_rd == idex_rs2)) begin
            fwd_b = 2'b01;
         end

         byp_a = memwb_fwd_ok && (memwb_rd == id_rs1);
         byp_b = memwb_fwd_ok && (memwb_rd == id_rs2);
      end
   end

   // ------------------------------------------------------------------------------------
   // Data-memory wait FSM
   // ------------------------------------------------------------------------------------

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_err_d = mem_err_q;
      freeze    = 1'b0;

      case (state_q)
         StRun: begin
            if (dmem_req && !dmem_ready) begin
               freeze  = 1'b1;
               state_d = StMemWait;
               wcnt_d  = '0;
            end
         end
         StMemWait: begin
            // The timeout cycle itself is released exactly like a ready cycle.
            if (dmem_ready || (wcnt_q == WcntLast)) begin
               state_d = StRun;
               wcnt_d  = '0;
            end else begin
               freeze = 1'b1;
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StRun;
            wcnt_d  = '0;
         end
      endcase

      // Flag the timeout on the clock that ends the last frozen cycle, so it is already
      // visible during the forced-release cycle.
      if (freeze && (wcnt_d == WcntLast)) begin
         mem_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StRun;
         wcnt_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

   // ------------------------------------------------------------------------------------
   // Pipeline control, priority: reset > freeze > redirect > load-use > normal
   // ------------------------------------------------------------------------------------

   always_comb begin
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      id_ex_write     = 1'b1;
      ex_mem_write    = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_flush    = 1'b0;
      mem_wb_bubble   = 1'b0;
      pc_sel_redirect = 1'b0;

      if (reset) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_flush  = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (freeze) begin
         // Hold every stage; only MEM/WB drains as a bubble. A pending redirect stays
         // asserted by the held stage and is taken once the freeze releases.
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (redirect) begin
         pc_sel_redirect = 1'b1;
         if_id_flush     = 1'b1;
         id_ex_flush     = 1'b1;
         ex_mem_flush    = RedirFlushExMem;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // ------------------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------------------

`ifdef HAZARD_PERF_CNT_EN
   logic             stall_evt;
   logic             flush_evt;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // A load-use hit shadowed by a redirect is not a stall.
   assign stall_evt = freeze || (!redirect && load_use);
   assign flush_evt = !freeze && redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share one stimulus stream:
//   dut 0: BRANCH_STAGE=3, MEM_TIMEOUT=4,  CNT_W=4
//   dut 1: BRANCH_STAGE=2, MEM_TIMEOUT=16, CNT_W=16
// A behavioural model tracks, per instance, how many consecutive frozen cycles the current
// memory access has cost, and derives all outputs from the priority rules.
module tb_pipe_hazard_ctrl;

   localparam int AW = 5;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic clk;
   logic reset;
   logic [AW-1:0] id_rs1, id_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
   logic id_use_rs1, id_use_rs2, idex_reg_write, idex_is_load;
   logic exmem_reg_write, exmem_is_load, memwb_reg_write;
   logic redirect, dmem_req, dmem_ready;

   logic       pc_write_w [2];
   logic       if_id_write_w [2];
   logic       id_ex_write_w [2];
   logic       ex_mem_write_w [2];
   logic       if_id_flush_w [2];
   logic       id_ex_flush_w [2];
   logic       ex_mem_flush_w [2];
   logic       mem_wb_bubble_w [2];
   logic       pc_sel_w [2];
   logic [1:0] fwd_a_w [2];
   logic [1:0] fwd_b_w [2];
   logic       byp_a_w [2];
   logic       byp_b_w [2];
   logic       mem_err_w [2];
   logic [3:0]  stall0, flush0;
   logic [15:0] stall1, flush1;

   pipe_hazard_ctrl #(
      .REG_AW(AW), .BRANCH_STAGE(3), .MEM_TIMEOUT(4), .CNT_W(4)
   ) u_dut0 (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .idex_rd(idex_rd), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
      .idex_reg_write(idex_reg_write), .idex_is_load(idex_is_load),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
      .redirect(redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write_w[0]), .if_id_write(if_id_write_w[0]),
      .id_ex_write(id_ex_write_w[0]), .ex_mem_write(ex_mem_write_w[0]),
      .if_id_flush(if_id_flush_w[0]), .id_ex_flush(id_ex_flush_w[0]),
      .ex_mem_flush(ex_mem_flush_w[0]), .mem_wb_bubble(mem_wb_bubble_w[0]),
      .pc_sel_redirect(pc_sel_w[0]),
      .fwd_a(fwd_a_w[0]), .fwd_b(fwd_b_w[0]), .byp_a(byp_a_w[0]), .byp_b(byp_b_w[0]),
      .mem_err(mem_err_w[0]), .stall_cnt(stall0), .flush_cnt(flush0)
   );

   pipe_hazard_ctrl #(
      .REG_AW(AW), .BRANCH_STAGE(2), .MEM_TIMEOUT(16), .CNT_W(16)
   ) u_dut1 (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .idex_rd(idex_rd), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
      .idex_reg_write(idex_reg_write), .idex_is_load(idex_is_load),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
      .redirect(redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write_w[1]), .if_id_write(if_id_write_w[1]),
      .id_ex_write(id_ex_write_w[1]), .ex_mem_write(ex_mem_write_w[1]),
      .if_id_flush(if_id_flush_w[1]), .id_ex_flush(id_ex_flush_w[1]),
      .ex_mem_flush(ex_mem_flush_w[1]), .mem_wb_bubble(mem_wb_bubble_w[1]),
      .pc_sel_redirect(pc_sel_w[1]),
      .fwd_a(fwd_a_w[1]), .fwd_b(fwd_b_w[1]), .byp_a(byp_a_w[1]), .byp_b(byp_b_w[1]),
      .mem_err(mem_err_w[1]), .stall_cnt(stall1), .flush_cnt(flush1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // ---------------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------------
   int t_m [2]    = '{4, 16};
   int bs_m [2]   = '{3, 2};
   int cmax_m [2] = '{15, 65535};
   int n_m [2]    = '{0, 0};   // frozen cycles spent so far on the current access
   bit err_m [2]  = '{0, 0};
   int sc_m [2]   = '{0, 0};
   int fc_m [2]   = '{0, 0};
   int nn_m [2], nsc_m [2], nfc_m [2];
   bit nerr_m [2];

   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
      if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs && !exmem_is_load) return 2'b10;
      if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [15:0] act_ctl(input int i);
      return {pc_write_w[i], if_id_write_w[i], id_ex_write_w[i], ex_mem_write_w[i],
              if_id_flush_w[i], id_ex_flush_w[i], ex_mem_flush_w[i], mem_wb_bubble_w[i],
              pc_sel_w[i], fwd_a_w[i], fwd_b_w[i], byp_a_w[i], byp_b_w[i], mem_err_w[i]};
   endfunction

   always begin
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            bit frz, lu;
            logic [3:0] we, fl;
            logic psel, ba, bb;
            logic [1:0] fa, fb;
            int es, ef;
            logic [31:0] as, af;
            // An access already waiting releases on ready or after t_m frozen cycles.
            if (n_m[i] == 0) frz = dmem_req && !dmem_ready;
            else frz = !dmem_ready && (n_m[i] < t_m[i]);
            lu = idex_is_load && idex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == idex_rd) || (id_use_rs2 && id_rs2 == idex_rd));
            fa = fwd_sel(idex_rs1);
            fb = fwd_sel(idex_rs2);
            ba = memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs1;
            bb = memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs2;
            psel = 1'b0;
            if (reset) begin
               we = 4'b0000; fl = 4'b1111; fa = 2'b00; fb = 2'b00; ba = 1'b0; bb = 1'b0;
            end else if (frz) begin
               we = 4'b0000; fl = 4'b0001;
            end else if (redirect) begin
               we = 4'b1111; fl = {2'b11, (bs_m[i] == 3), 1'b0}; psel = 1'b1;
            end else if (lu) begin
               we = 4'b0011; fl = 4'b0100;
            end else begin
               we = 4'b1111; fl = 4'b0000;
            end
            chk($sformatf("ctl%0d", i), 32'(act_ctl(i)),
                32'({we, fl, psel, fa, fb, ba, bb, err_m[i]}));
            es = PerfEn ? sc_m[i] : 0;
            ef = PerfEn ? fc_m[i] : 0;
            as = (i == 0) ? 32'(stall0) : 32'(stall1);
            af = (i == 0) ? 32'(flush0) : 32'(flush1);
            chk($sformatf("stall_cnt%0d", i), as, es);
            chk($sformatf("flush_cnt%0d", i), af, ef);
            // next model state
            if (reset) begin
               nn_m[i] = 0; nerr_m[i] = 1'b0; nsc_m[i] = 0; nfc_m[i] = 0;
            end else begin
               nn_m[i] = frz ? n_m[i] + 1 : 0;
               nerr_m[i] = err_m[i] || (frz && nn_m[i] == t_m[i]);
               nsc_m[i] = sc_m[i];
               nfc_m[i] = fc_m[i];
               if ((frz || (!redirect && lu)) && sc_m[i] < cmax_m[i]) nsc_m[i] = sc_m[i] + 1;
               if (!frz && redirect && fc_m[i] < cmax_m[i]) nfc_m[i] = fc_m[i] + 1;
            end
         end
      end
      @(posedge clk);
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            n_m[i] = nn_m[i]; err_m[i] = nerr_m[i]; sc_m[i] = nsc_m[i]; fc_m[i] = nfc_m[i];
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      idex_rd = '0; idex_rs1 = '0; idex_rs2 = '0; idex_reg_write = 1'b0; idex_is_load = 1'b0;
      exmem_rd = '0; exmem_reg_write = 1'b0; exmem_is_load = 1'b0;
      memwb_rd = '0; memwb_reg_write = 1'b0;
      redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic set_load_use();
      idex_is_load = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd5;
      id_rs1 = 5'd5; id_use_rs1 = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      clr();
      // reset
      cyc(); chk_en = 1'b1; smp();
      chk("rst_pc_write", 32'(pc_write_w[0]), 0);
      chk("rst_flushes", 32'({if_id_flush_w[0], id_ex_flush_w[0], ex_mem_flush_w[0]}), 7);
      chk("rst_bubble", 32'(mem_wb_bubble_w[0]), 1);
      cyc(); smp();
      cyc(); reset = 1'b0; smp();
      chk("run_pc_write", 32'(pc_write_w[0]), 1);

      // load-use: one stall cycle
      cyc(); set_load_use(); smp();
      chk("lu_pc_write", 32'(pc_write_w[0]), 0);
      chk("lu_if_id_write", 32'(if_id_write_w[0]), 0);
      chk("lu_id_ex_flush", 32'(id_ex_flush_w[0]), 1);
      cyc(); clr(); smp();
      chk("lu_after_pc_write", 32'(pc_write_w[0]), 1);
      chk("lu_stall_cnt", 32'(stall0), PerfEn ? 1 : 0);

      // forwarding priority
      cyc();
      idex_rs2 = 5'd7; exmem_rd = 5'd7; memwb_rd = 5'd7; id_rs1 = 5'd7;
      exmem_reg_write = 1'b1; memwb_reg_write = 1'b1;
      smp();
      chk("fwd_b_exmem", 32'(fwd_b_w[0]), 2);
      chk("byp_a_hit", 32'(byp_a_w[0]), 1);
      cyc(); exmem_is_load = 1'b1; smp();
      chk("fwd_b_memwb", 32'(fwd_b_w[0]), 1);
      cyc(); exmem_rd = '0; memwb_rd = '0; idex_rs2 = '0; smp();
      chk("fwd_b_none", 32'(fwd_b_w[0]), 0);
      chk("byp_a_none", 32'(byp_a_w[0]), 0);

      // memory wait: 3 frozen cycles, release on ready
      for (int k = 0; k < 3; k++) begin
         cyc(); clr(); dmem_req = 1'b1; smp();
         chk("wait_bubble", 32'(mem_wb_bubble_w[0]), 1);
         chk("wait_pc_write", 32'(pc_write_w[0]), 0);
      end
      cyc(); dmem_ready = 1'b1; smp();
      chk("wait_release", 32'(pc_write_w[0]), 1);
      chk("wait_no_err", 32'(mem_err_w[0]), 0);

      // timeout on dut0: exactly 4 frozen cycles
      for (int k = 0; k < 4; k++) begin
         cyc(); dmem_ready = 1'b0; smp();
         chk("to_frozen", 32'(mem_wb_bubble_w[0]), 1);
      end
      cyc(); smp();
      chk("to_release", 32'({pc_write_w[0], if_id_write_w[0]}), 3);
      chk("to_err0", 32'(mem_err_w[0]), 1);
      chk("to_err1", 32'(mem_err_w[1]), 0);
      cyc(); dmem_req = 1'b0; dmem_ready = 1'b1; smp();
      chk("to_err_hold", 32'(mem_err_w[0]), 1);
      cyc(); dmem_ready = 1'b0; smp();
      chk("to_err_hold2", 32'(mem_err_w[0]), 1);

      // redirect beats a simultaneous load-use
      cyc(); set_load_use(); redirect = 1'b1; smp();
      chk("rd_pc_sel", 32'(pc_sel_w[0]), 1);
      chk("rd_pc_write", 32'(pc_write_w[0]), 1);
      chk("rd_flush_bs3", 32'({if_id_flush_w[0], id_ex_flush_w[0], ex_mem_flush_w[0]}), 7);
      chk("rd_flush_bs2", 32'({if_id_flush_w[1], id_ex_flush_w[1], ex_mem_flush_w[1]}), 6);
      cyc(); clr(); smp();
      chk("rd_flush_cnt", 32'(flush0), PerfEn ? 1 : 0);

      // reset in the middle of a wait
      for (int k = 0; k < 2; k++) begin
         cyc(); dmem_req = 1'b1; smp();
      end
      cyc(); reset = 1'b1; smp();
      cyc(); reset = 1'b0; clr(); smp();
      chk("rmw_mem_err", 32'(mem_err_w[0]), 0);
      chk("rmw_run", 32'(pc_write_w[0]), 1);
      chk("rmw_cnts", 32'({stall0, flush0}), 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         cyc();
         reset = ($urandom_range(0, 299) == 0);
         id_rs1 = AW'($urandom_range(0, 3));
         id_rs2 = AW'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom_range(0, 1));
         id_use_rs2 = 1'($urandom_range(0, 1));
         idex_rd = AW'($urandom_range(0, 3));
         idex_rs1 = AW'($urandom_range(0, 3));
         idex_rs2 = AW'($urandom_range(0, 3));
         idex_reg_write = 1'($urandom_range(0, 1));
         idex_is_load = 1'($urandom_range(0, 1));
         exmem_rd = AW'($urandom_range(0, 3));
         exmem_reg_write = 1'($urandom_range(0, 1));
         exmem_is_load = 1'($urandom_range(0, 1));
         memwb_rd = AW'($urandom_range(0, 3));
         memwb_reg_write = 1'($urandom_range(0, 1));
         redirect = ($urandom_range(0, 4) == 0);
         dmem_req = ($urandom_range(0, 3) == 0);
         dmem_ready = ($urandom_range(0, 3) == 0);
      end
      cyc(); smp();
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
